// File: rtl/config_lut_bank_pkg.sv
// Shared types and helpers for config_lut_bank (states, width helper).
package config_lut_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/config_lut_bank_lut_read_mux.sv
// lut_read_mux: one truth table plus its address gives one output bit.
module lut_read_mux #(
  parameter int ADDR_BITS = 4,
  parameter int MEM_SIZE  = 2 ** ADDR_BITS
) (
  input  logic [MEM_SIZE-1:0]  table_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  output logic                 bit_o
);

  assign bit_o = table_i[addr_i];

endmodule

// File: rtl/config_lut_bank.sv
// config_lut_bank: shadow-loaded, atomically committed LUT bank.
// Optional CFG_PARITY_EN adds per-word even parity on config_parity.
module config_lut_bank
  import config_lut_bank_pkg::*;
#(
  parameter int ADDR_BITS = 4,
  parameter int NUM_LUTS  = 2,
  parameter int CFG_WIDTH = 8
) (
  input  logic                          cclk,
  input  logic                          rst_n,
  input  logic [NUM_LUTS*ADDR_BITS-1:0] addr,
  output logic [NUM_LUTS-1:0]           out,
  input  logic                          cen,
  output logic                          config_ready,
  input  logic [CFG_WIDTH-1:0]          config_in,
  input  logic                          config_last,
`ifdef CFG_PARITY_EN
  input  logic                          config_parity,
`endif
  output logic [CFG_WIDTH-1:0]          config_out,
  output logic                          config_done,
  output logic                          config_err
);

  localparam int MEM_SIZE = 2 ** ADDR_BITS;
  localparam int TOTAL    = NUM_LUTS * MEM_SIZE;
  localparam int WORDS    = TOTAL / CFG_WIDTH;
  localparam int CNT_W    = clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);

  if ((TOTAL % CFG_WIDTH) != 0 || CFG_WIDTH > TOTAL) begin : g_bad_cfg
    $error("config_lut_bank: TOTAL must be a multiple of CFG_WIDTH");
  end

  cfg_state_e       state_q, state_d;
  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [TOTAL-1:0] active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             bad_q, bad_d;

  logic             accept;
  logic             word_bad;
  logic [TOTAL-1:0] word_ext;
  logic [CNT_W-1:0] cnt_new;
  logic             bad_new;

  assign accept = cen & config_ready;
  assign word_ext = TOTAL'(config_in);

`ifdef CFG_PARITY_EN
  assign word_bad = ^{config_in, config_parity};
`else
  assign word_bad = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    bad_d    = bad_q;
    cnt_new  = cnt_q;
    bad_new  = bad_q;
    if (accept) begin
      shadow_d = (shadow_q >> CFG_WIDTH)
               | (word_ext << (TOTAL - CFG_WIDTH));
    end
    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          if (state_q == ST_IDLE) begin
            err_d   = 1'b0;
            cnt_new = CNT_W'(1);
            bad_new = word_bad;
          end else begin
            cnt_new = (cnt_q == WORDS_C) ? cnt_q : cnt_q + 1'b1;
            bad_new = bad_q | word_bad;
          end
          cnt_d = cnt_new;
          bad_d = bad_new;
          state_d = ST_LOAD;
          // Short or corrupted loads leave the active tables untouched
          if (config_last) begin
            if (cnt_new >= WORDS_C && !bad_new) begin
              state_d = ST_COMMIT;
            end else begin
              err_d   = 1'b1;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_COMMIT: begin
        active_d = shadow_q;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      bad_q    <= bad_d;
    end
  end

  assign config_ready = (state_q != ST_COMMIT);
  assign config_done  = (state_q == ST_COMMIT);
  assign config_err   = err_q;
  assign config_out   = shadow_q[CFG_WIDTH-1:0];

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
    lut_read_mux #(
      .ADDR_BITS(ADDR_BITS),
      .MEM_SIZE (MEM_SIZE)
    ) u_mux (
      .table_i(active_q[i*MEM_SIZE +: MEM_SIZE]),
      .addr_i (addr[i*ADDR_BITS +: ADDR_BITS]),
      .bit_o  (out[i])
    );
  end

endmodule
